// File: rtl/seg_share_pkg.sv
// Shared types and constants for the shared 7-segment display scheduler.
//   seg_t          : 7-bit segment pattern, bit0=a ... bit6=g, active high
//   SEG_BLANK      : all segments off
//   SEG_DASH       : middle segment only (g)
//   HEX_SEG_TABLE  : hex digit 0..F to segment pattern
//   sched_state_e  : scheduler ownership state
package seg_share_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_DASH  = 7'h40;

    localparam seg_t HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } sched_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to 7-segment decoder.
//   nibble_i : 4-bit hex digit
//   seg_o    : active-high segment pattern (bit0=a ... bit6=g)
module seg_hex_decode
    import seg_share_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_share_sched.sv
// Round-robin scheduler sharing one 2-digit multiplexed 7-segment display
// among NREQ requesters, with a minimum hold time per owner.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   req          : per-requester level request
//   data         : requester i value at data[8*i+7:8*i], high nibble = left digit
//   grant        : registered one-hot owner, zero when idle
//   segment      : active-high segments (bit0=a ... bit6=g)
//   digit_select : 1 = left (high nibble) digit, 0 = right digit
//   busy         : an owner exists
// Optional build macro SEG_IDLE_DASH_EN: when defined, the idle display
// shows a dash on both digits instead of blanking.
module seg_share_sched
    import seg_share_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int SCAN_CYCLES = 500,
    parameter int HOLD_FRAMES = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   grant,
    output seg_t              segment,
    output logic              digit_select,
    output logic              busy
);

    localparam int CBITS = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int RRW   = $clog2(NREQ);
    localparam int HBITS = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(SCAN_CYCLES - 1);
    localparam logic [HBITS-1:0] HOLD_MAX = HBITS'(HOLD_FRAMES - 1);

`ifdef SEG_IDLE_DASH_EN
    localparam seg_t IDLE_SEG = SEG_DASH;
`else
    localparam seg_t IDLE_SEG = SEG_BLANK;
`endif

    logic [CBITS-1:0] cnt_q, cnt_d;
    logic             dsel_q, dsel_d;
    seg_t             seg_q, seg_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [HBITS-1:0] hold_q, hold_d;
    logic [RRW-1:0]   rr_q, rr_d;
    sched_state_e     state_q, state_d;

    logic             tick;
    logic             frame_end;
    logic [7:0]       owner_data;
    logic [3:0]       nibble;
    seg_t             dec_seg;
    logic [NREQ-1:0]  pending;
    logic             found;
    logic [RRW-1:0]   win_idx;
    logic             owner_req;
    logic             hold_done;

    // Scan timing: the frame ends on the tick that returns to the right digit
    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick & dsel_q;
    assign cnt_d     = tick ? '0 : cnt_q + CBITS'(1);
    assign dsel_d    = tick ? ~dsel_q : dsel_q;

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                owner_data = owner_data | data[8*i +: 8];
            end
        end
    end

    // The digit being switched to decides which nibble is shown
    assign nibble = dsel_d ? owner_data[7:4] : owner_data[3:0];

    seg_hex_decode u_dec (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    // Segment uses the owner in place before this edge's arbitration
    always_comb begin
        seg_d = seg_q;
        if (tick) begin
            seg_d = (state_q == ST_OWNED) ? dec_seg : IDLE_SEG;
        end
    end

    // Rotated search from rr+1; the current owner is excluded so a
    // hand-off always goes to someone else
    assign pending = req & ~grant_q;

    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && pending[idx]) begin
                found   = 1'b1;
                win_idx = RRW'(idx);
            end
        end
    end

    assign owner_req = |(req & grant_q);
    assign hold_done = (int'(hold_q) + 1) >= HOLD_FRAMES;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        state_d = ST_OWNED;
                        grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        hold_d  = '0;
                        rr_d    = win_idx;
                    end
                end
                ST_OWNED: begin
                    if ((!owner_req || hold_done) && found) begin
                        grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        hold_d  = '0;
                        rr_d    = win_idx;
                    end else if (!owner_req) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HBITS'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            dsel_q  <= 1'b0;
            seg_q   <= SEG_BLANK;
            grant_q <= '0;
            hold_q  <= '0;
            rr_q    <= '0;
            state_q <= ST_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            dsel_q  <= dsel_d;
            seg_q   <= seg_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            state_q <= state_d;
        end
    end

    assign grant        = grant_q;
    assign segment      = seg_q;
    assign digit_select = dsel_q;
    assign busy         = |grant_q;

endmodule
